// File: rtl/sha256_msg_sequencer_if.sv
// Bundle of the message stream, compression-core and digest handshakes of the
// SHA-256 message sequencer. The slave modport is the sequencer's view; the
// master modport is the surrounding logic (message source, core, digest sink).
interface sha256_msg_sequencer_if;
    // message word stream
    logic [31:0]  s_data;
    logic [2:0]   s_nbytes;
    logic         s_last;
    logic         s_valid;
    logic         s_ready;
    // compression core
    logic [511:0] core_block;
    logic         core_start;
    logic         core_first_run;
    logic [255:0] core_hash;
    logic         core_ready;
    // digest output
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ready;

    modport master (
        output s_data,
        output s_nbytes,
        output s_last,
        output s_valid,
        input  s_ready,
        input  core_block,
        input  core_start,
        input  core_first_run,
        output core_hash,
        output core_ready,
        input  digest,
        input  digest_valid,
        output digest_ready
    );

    modport slave (
        input  s_data,
        input  s_nbytes,
        input  s_last,
        input  s_valid,
        output s_ready,
        output core_block,
        output core_start,
        output core_first_run,
        input  core_hash,
        input  core_ready,
        output digest,
        output digest_valid,
        input  digest_ready
    );
endinterface

// File: rtl/sha256_msg_sequencer.sv
// SHA-256 front end: packs a big-endian 32-bit word stream into 512-bit
// blocks, appends the 0x80 marker, zero fill and 64-bit bit length, drives the
// compression core once per block and returns the final digest on a
// valid/ready output. All outputs come straight from registers.
module sha256_msg_sequencer #(
    parameter int LEN_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    sha256_msg_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        FILL   = 3'd0,
        PAD    = 3'd1,
        LEN    = 3'd2,
        ISSUE  = 3'd3,
        SETTLE = 3'd4,
        WAIT   = 3'd5,
        OUT    = 3'd6
    } state_t;

    state_t state_reg;
    state_t state_next;
    state_t resume_reg;
    state_t resume_next;

    // Block assembly bookkeeping; word_idx runs 0..16, bit 4 marks a full block.
    logic [4:0]       word_idx_reg;
    logic [4:0]       idx_inc;
    logic [LEN_W-1:0] bytes_reg;
    logic             first_reg;
    logic             pad_pending_reg;
    logic             final_reg;
    logic [255:0]     digest_reg;

    // Registered handshake outputs and their next values.
    logic             s_ready_reg;
    logic             core_start_reg;
    logic             digest_valid_reg;
    logic             s_ready_next;
    logic             core_start_next;
    logic             digest_valid_next;

    // Block write controls shared by all sixteen word registers.
    logic             accept;
    logic             out_take;
    logic             word_wr;
    logic [31:0]      word_data;
    logic [31:0]      fill_word;
    logic [31:0]      pad_word;
    logic             len_wr;
    logic             block_clr;
    logic [63:0]      len_bits;

    assign accept    = s_ready_reg & bus.s_valid;
    assign out_take  = digest_valid_reg & bus.digest_ready;
    assign idx_inc   = word_idx_reg + 5'd1;
    assign len_bits  = 64'({bytes_reg, 3'b000});
    assign pad_word  = pad_pending_reg ? 32'h8000_0000 : 32'h0000_0000;
    assign len_wr    = (state_reg == LEN);
    // Once the core has finished with a block the buffer is wiped so that a
    // short final block never carries words left over from an earlier block.
    assign block_clr = (state_reg == WAIT) && bus.core_ready;

    // Per-byte shaping of an incoming word: a short last word keeps its first
    // n bytes, gets the 0x80 marker in byte n and zeros after that.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign fill_word[31-8*gi -: 8] =
                (!bus.s_last || (3'(gi) < bus.s_nbytes)) ? bus.s_data[31-8*gi -: 8] :
                (3'(gi) == bus.s_nbytes)                 ? 8'h80 :
                                                           8'h00;
        end
    endgenerate

    // Select which single-word write (stream data or padding) lands this cycle.
    always_comb begin
        word_wr   = 1'b0;
        word_data = fill_word;
        if ((state_reg == FILL) && accept) begin
            word_wr = 1'b1;
        end else if ((state_reg == PAD) && !word_idx_reg[4]) begin
            word_wr   = 1'b1;
            word_data = pad_word;
        end
    end

    // Sixteen block word registers; word 0 sits in the top 32 bits of core_block.
    generate
        for (gi = 0; gi < 16; gi++) begin : g_word
            logic [31:0] word_reg;

            // Word update: clear after use, length words in LEN, else indexed write.
            always_ff @(posedge clk) begin
                if (rst) begin
                    word_reg <= '0;
                end else if (block_clr) begin
                    word_reg <= '0;
                end else if (len_wr && (gi == 14)) begin
                    word_reg <= len_bits[63:32];
                end else if (len_wr && (gi == 15)) begin
                    word_reg <= len_bits[31:0];
                end else if (word_wr && (word_idx_reg[3:0] == 4'(gi))) begin
                    word_reg <= word_data;
                end
            end

            assign bus.core_block[511-32*gi -: 32] = word_reg;
        end
    endgenerate

    // State register together with the state to return to after a mid-message block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= FILL;
            resume_reg <= FILL;
        end else begin
            state_reg  <= state_next;
            resume_reg <= resume_next;
        end
    end

    // Next-state logic for block assembly, padding and the core handshake.
    always_comb begin
        state_next  = state_reg;
        resume_next = resume_reg;
        case (state_reg)
            FILL: begin
                if (accept) begin
                    if (!bus.s_last) begin
                        if (idx_inc == 5'd16) begin
                            state_next  = ISSUE;
                            resume_next = FILL;
                        end
                    end else if (bus.s_nbytes < 3'd4) begin
                        // Marker already placed; length fits only if words 14/15 are free.
                        state_next = (idx_inc <= 5'd14) ? LEN : PAD;
                    end else if (idx_inc == 5'd16) begin
                        state_next  = ISSUE;
                        resume_next = PAD;
                    end else begin
                        state_next = PAD;
                    end
                end
            end
            PAD: begin
                if (word_idx_reg[4] || (idx_inc == 5'd16)) begin
                    state_next  = ISSUE;
                    resume_next = PAD;
                end else if (idx_inc == 5'd14) begin
                    state_next = LEN;
                end
            end
            LEN:    state_next = ISSUE;
            ISSUE:  state_next = SETTLE;
            // The core's ready from the previous block is still visible here.
            SETTLE: state_next = WAIT;
            WAIT: begin
                if (bus.core_ready) begin
                    state_next = final_reg ? OUT : resume_reg;
                end
            end
            OUT: begin
                if (out_take) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Handshake outputs follow the state being entered so they register cleanly.
    always_comb begin
        s_ready_next      = (state_next == FILL);
        core_start_next   = (state_next == ISSUE);
        digest_valid_next = (state_next == OUT);
    end

    // Output registers; s_ready stays low for the reset cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready_reg      <= 1'b0;
            core_start_reg   <= 1'b0;
            digest_valid_reg <= 1'b0;
        end else begin
            s_ready_reg      <= s_ready_next;
            core_start_reg   <= core_start_next;
            digest_valid_reg <= digest_valid_next;
        end
    end

    // Word index, byte count, padding flags, first-block flag and digest capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_idx_reg    <= '0;
            bytes_reg       <= '0;
            first_reg       <= 1'b1;
            pad_pending_reg <= 1'b0;
            final_reg       <= 1'b0;
            digest_reg      <= '0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (accept) begin
                        word_idx_reg <= idx_inc;
                        bytes_reg    <= bytes_reg + LEN_W'(bus.s_nbytes);
                        // A full last word leaves no room for the marker in this word.
                        if (bus.s_last && (bus.s_nbytes >= 3'd4)) begin
                            pad_pending_reg <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    if (!word_idx_reg[4]) begin
                        word_idx_reg    <= idx_inc;
                        pad_pending_reg <= 1'b0;
                    end
                    if (state_next == ISSUE) begin
                        final_reg <= 1'b0;
                    end
                end
                LEN: begin
                    final_reg <= 1'b1;
                end
                WAIT: begin
                    if (bus.core_ready) begin
                        first_reg    <= 1'b0;
                        word_idx_reg <= '0;
                        if (final_reg) begin
                            digest_reg <= bus.core_hash;
                        end
                    end
                end
                OUT: begin
                    if (out_take) begin
                        first_reg    <= 1'b1;
                        bytes_reg    <= '0;
                        final_reg    <= 1'b0;
                        word_idx_reg <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.s_ready        = s_ready_reg;
    assign bus.core_start     = core_start_reg;
    assign bus.core_first_run = first_reg;
    assign bus.digest         = digest_reg;
    assign bus.digest_valid   = digest_valid_reg;

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Bench for sha256_msg_sequencer: a behavioural SHA-256 core answers the
// start/ready handshake, a table of messages is streamed in and each block,
// first_run flag and digest is checked against known answers or a reference
// padding/hash model; hand sequences cover digest backpressure and reset in WAIT.
module tb_sha256_msg_sequencer;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic clk;
    logic rst;
    sha256_msg_sequencer_if bus();

    sha256_msg_sequencer #(.LEN_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- SHA-256 reference ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    function automatic int ref_nblk(input int len);
        return (len + 8) / 64 + 1;
    endfunction

    function automatic logic [511:0] ref_block(input string m, input int bi);
        logic [511:0] r;
        logic [63:0]  lb;
        logic [7:0]   by;
        int           len, pos, total;
        len   = m.len();
        total = ref_nblk(len) * 64;
        lb    = 64'(len) * 64'd8;
        r     = '0;
        for (int j = 0; j < 64; j++) begin
            pos = bi * 64 + j;
            if (pos < len)             by = m[pos];
            else if (pos == len)       by = 8'h80;
            else if (pos >= total - 8) by = lb[63-8*(pos-(total-8)) -: 8];
            else                       by = 8'h00;
            r[511-8*j -: 8] = by;
        end
        return r;
    endfunction

    function automatic logic [255:0] sha256_ref(input string m);
        logic [255:0] hv;
        hv = IV;
        for (int b = 0; b < ref_nblk(m.len()); b++) hv = compress(hv, ref_block(m, b));
        return hv;
    endfunction

    // ---------------- behavioural compression core ----------------
    int           core_cnt;
    logic [255:0] core_pend;
    always @(posedge clk) begin
        if (rst) begin
            bus.core_ready <= 1'b0;
            bus.core_hash  <= '0;
            core_cnt       <= 0;
            core_pend      <= '0;
        end else if (bus.core_start) begin
            core_cnt  <= 67;
            core_pend <= compress(bus.core_first_run ? IV : bus.core_hash, bus.core_block);
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 67) bus.core_ready <= 1'b0;   // stale ready drops a cycle after start
            if (core_cnt == 1) begin
                bus.core_ready <= 1'b1;
                bus.core_hash  <= core_pend;
            end
        end
    end

    // ---------------- start monitor ----------------
    int           start_count = 0;
    logic         first_q [$];
    logic [511:0] block_q [$];
    always @(negedge clk) begin
        if (!rst && bus.core_start) begin
            start_count <= start_count + 1;
            first_q.push_back(bus.core_first_run);
            block_q.push_back(bus.core_block);
        end
    end

    // Protocol check on the input stream.
    always @(negedge clk) begin
        if (!rst && bus.s_valid)
            assert (bus.s_nbytes <= 3'd4 && (bus.s_last || bus.s_nbytes == 3'd4))
                else $error("input protocol violation: nbytes=%0d last=%0b", bus.s_nbytes, bus.s_last);
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, got);
        end
    endtask

    // Present one word from a negedge and hold it until accepted.
    task automatic drive_word(input logic [31:0] d, input logic [2:0] n, input logic last);
        int   t;
        logic acc;
        bus.s_data   = d;
        bus.s_nbytes = n;
        bus.s_last   = last;
        bus.s_valid  = 1'b1;
        t   = 0;
        acc = 1'b0;
        while (!acc && t < 3000) begin
            acc = bus.s_ready;
            @(negedge clk);
            t++;
        end
        bus.s_valid = 1'b0;
        check("word_accepted", 512'(acc), 512'(1));
    endtask

    task automatic send_msg(input string m);
        int len, nw, nb;
        logic [31:0] d;
        len = m.len();
        nw  = (len == 0) ? 1 : (len + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            d  = '0;
            nb = (i == nw - 1) ? len - 4 * i : 4;
            for (int j = 0; j < 4; j++)
                if (4 * i + j < len) d[31-8*j -: 8] = m[4*i+j];
            drive_word(d, 3'(nb), i == nw - 1);
        end
    endtask

    task automatic wait_digest();
        int t;
        t = 0;
        while (!bus.digest_valid && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("digest_valid_rises", 512'(bus.digest_valid), 512'(1));
    endtask

    task automatic take_digest();
        bus.digest_ready = 1'b1;
        @(negedge clk);
        bus.digest_ready = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string        msg;
        int           exp_starts;
        logic [31:0]  exp_w0;      // word 0 of the last block
        logic [31:0]  exp_w15;     // word 15 of the last block
        logic         use_const;
        logic [255:0] exp_digest;
    } vec_t;

    vec_t tv [5];

    initial begin
        int           base, nblk, t, saw_dv;
        logic [255:0] expd;
        logic [511:0] lastb;

        tv[0] = '{"abc", 1, 32'h61626380, 32'h00000018, 1'b1, ABC_DIGEST};
        tv[1] = '{"", 1, 32'h80000000, 32'h00000000, 1'b1,
                  256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855};
        tv[2] = '{"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 2,
                  32'h00000000, 32'h000001c0, 1'b1,
                  256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1};
        tv[3] = '{"abcdefghijklmnopqrstuvwxyz0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZ-_", 2,
                  32'h80000000, 32'h00000200, 1'b0, '0};
        tv[4] = '{"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnop", 1,
                  32'h61626364, 32'h000001b8, 1'b0, '0};

        rst              = 1'b1;
        bus.s_data       = '0;
        bus.s_nbytes     = '0;
        bus.s_last       = 1'b0;
        bus.s_valid      = 1'b0;
        bus.digest_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_s_ready", 512'(bus.s_ready), 512'(0));
        check("rst_core_start", 512'(bus.core_start), 512'(0));
        check("rst_first_run", 512'(bus.core_first_run), 512'(1));
        check("rst_core_block", bus.core_block, 512'(0));
        check("rst_digest", 512'(bus.digest), 512'(0));
        check("rst_digest_valid", 512'(bus.digest_valid), 512'(0));
        rst = 1'b0;
        @(negedge clk);
        check("fill_s_ready", 512'(bus.s_ready), 512'(1));

        // Table-driven messages.
        for (int v = 0; v < 5; v++) begin
            base = start_count;
            nblk = ref_nblk(tv[v].msg.len());
            send_msg(tv[v].msg);
            wait_digest();
            check($sformatf("v%0d_starts", v), 512'(start_count - base), 512'(tv[v].exp_starts));
            for (int b = 0; b < nblk && base + b < start_count; b++) begin
                check($sformatf("v%0d_b%0d_first_run", v, b), 512'(first_q[base+b]), 512'(b == 0));
                check($sformatf("v%0d_b%0d_block", v, b), block_q[base+b], ref_block(tv[v].msg, b));
            end
            if (start_count > base) begin
                lastb = block_q[start_count-1];
                check($sformatf("v%0d_last_w0", v), 512'(lastb[511:480]), 512'(tv[v].exp_w0));
                check($sformatf("v%0d_last_w15", v), 512'(lastb[31:0]), 512'(tv[v].exp_w15));
            end
            expd = tv[v].use_const ? tv[v].exp_digest : sha256_ref(tv[v].msg);
            check($sformatf("v%0d_digest", v), 512'(bus.digest), 512'(expd));
            take_digest();
        end

        // Digest backpressure with a word waiting on the input.
        send_msg("abc");
        wait_digest();
        bus.s_data   = 32'h61626300;
        bus.s_nbytes = 3'd3;
        bus.s_last   = 1'b1;
        bus.s_valid  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d_digest", c), 512'(bus.digest), 512'(ABC_DIGEST));
            check($sformatf("hold%0d_valid", c), 512'(bus.digest_valid), 512'(1));
            check($sformatf("hold%0d_s_ready", c), 512'(bus.s_ready), 512'(0));
        end
        base = start_count;
        take_digest();
        check("release_s_ready", 512'(bus.s_ready), 512'(1));
        check("release_digest_valid", 512'(bus.digest_valid), 512'(0));
        @(negedge clk);                       // held word taken on this edge
        bus.s_valid = 1'b0;
        wait_digest();
        check("after_hold_starts", 512'(start_count - base), 512'(1));
        if (start_count > base)
            check("after_hold_first_run", 512'(first_q[base]), 512'(1));
        check("after_hold_digest", 512'(bus.digest), 512'(ABC_DIGEST));
        take_digest();

        // Reset 20 cycles into WAIT.
        send_msg("abc");
        t = 0;
        while (!bus.core_start && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("wait_rst_start_seen", 512'(bus.core_start), 512'(1));
        repeat (22) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("wait_rst_s_ready", 512'(bus.s_ready), 512'(0));
        check("wait_rst_core_start", 512'(bus.core_start), 512'(0));
        check("wait_rst_first_run", 512'(bus.core_first_run), 512'(1));
        check("wait_rst_core_block", bus.core_block, 512'(0));
        check("wait_rst_digest", 512'(bus.digest), 512'(0));
        check("wait_rst_digest_valid", 512'(bus.digest_valid), 512'(0));
        saw_dv = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (bus.digest_valid) saw_dv = 1;
        end
        check("wait_rst_no_digest", 512'(saw_dv), 512'(0));
        base = start_count;
        send_msg("abc");
        wait_digest();
        check("post_rst_starts", 512'(start_count - base), 512'(1));
        if (start_count > base) begin
            check("post_rst_first_run", 512'(first_q[base]), 512'(1));
            check("post_rst_block", block_q[base], ref_block("abc", 0));
        end
        check("post_rst_digest", 512'(bus.digest), 512'(ABC_DIGEST));
        take_digest();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
